// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
// Pure declarations; no timing or flow-control behaviour of its own.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrlState_t;

  localparam int DRAIN_CYCLES = 3;
  localparam int STALL_CNT_W  = 16;
  localparam int DRAIN_CNT_W  = 2;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] value);
    return (&value) ? value : value + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EXE and the operands of ID.
// Zero latency, purely combinational; no backpressure of its own.
module load_use_detect (
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  input  logic       exeMemRead,
  input  logic [4:0] exeRt,
  output logic       hazard
);

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  assign hazard = exeMemRead && (exeRt != 5'd0) &&
                  ((exeRt == idRs) || (idUsesRt && (exeRt == idRt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt control for a 5-stage pipeline; enables and flushes are same-cycle combinational.
// memBusy freezes every enable and all FSM state; halted and stallCount are registered.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             idRs,
  input  logic [4:0]             idRt,
  input  logic                   idUsesRt,
  input  logic                   exeMemRead,
  input  logic [4:0]             exeRt,
  input  logic                   exeBranchTaken,
  input  logic                   exeSyscall,
  input  logic                   memBusy,
  input  logic                   resume,
  output logic                   pcWrite,
  output logic                   ifIdWrite,
  output logic                   idExeWrite,
  output logic                   ifIdFlush,
  output logic                   idExeFlush,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stallCount
);

  ctrlState_t             state, nextState;
  logic [DRAIN_CNT_W-1:0] drainCnt, nextDrainCnt;
  logic                   loadUse;
  logic                   stallInc;

  load_use_detect uLoadUse (
    .idRs       (idRs),
    .idRt       (idRt),
    .idUsesRt   (idUsesRt),
    .exeMemRead (exeMemRead),
    .exeRt      (exeRt),
    .hazard     (loadUse)
  );

  always_comb begin
    pcWrite      = 1'b0;
    ifIdWrite    = 1'b0;
    idExeWrite   = 1'b0;
    ifIdFlush    = 1'b0;
    idExeFlush   = 1'b0;
    nextState    = state;
    nextDrainCnt = drainCnt;
    stallInc     = 1'b0;

    if (!reset) begin
      nextState    = RUN;
      nextDrainCnt = '0;
    end else if (memBusy) begin
      stallInc = (state == RUN);
    end else begin
      case (state)
        RUN: begin
          if (exeSyscall) begin
            ifIdWrite    = 1'b1;
            idExeWrite   = 1'b1;
            ifIdFlush    = 1'b1;
            idExeFlush   = 1'b1;
            nextState    = DRAIN;
            nextDrainCnt = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
          end else if (exeBranchTaken) begin
            pcWrite    = 1'b1;
            ifIdWrite  = 1'b1;
            idExeWrite = 1'b1;
            ifIdFlush  = 1'b1;
            idExeFlush = 1'b1;
          end else if (loadUse) begin
            idExeWrite = 1'b1;
            idExeFlush = 1'b1;
            stallInc   = 1'b1;
          end else begin
            pcWrite    = 1'b1;
            ifIdWrite  = 1'b1;
            idExeWrite = 1'b1;
          end
        end
        DRAIN: begin
          idExeWrite = 1'b1;
          idExeFlush = 1'b1;
          if (drainCnt <= DRAIN_CNT_W'(1)) begin
            nextState    = HALTED;
            nextDrainCnt = '0;
          end else begin
            nextDrainCnt = drainCnt - DRAIN_CNT_W'(1);
          end
        end
        HALTED: begin
          if (resume) nextState = RUN;
        end
        default: nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      drainCnt   <= '0;
      halted     <= 1'b0;
      stallCount <= '0;
    end else begin
      state    <= nextState;
      drainCnt <= nextDrainCnt;
      halted   <= (nextState == HALTED);
      if (stallInc) stallCount <= satInc(stallCount);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: idRs, idRt  input  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have port: idUsesRt  input  1  ID instruction reads rt as an operand.
REQ-005 SHALL have ports: exeMemRead  input  1, exeRt  input  5  load flag and load destination of the instruction in EXE.
REQ-006 SHALL have ports: exeBranchTaken  input  1, exeSyscall  input  1  branch resolved taken in EXE; syscall in EXE.
REQ-007 SHALL have ports: memBusy  input  1  data memory wait; resume  input  1  one-cycle restart pulse.
REQ-008 SHALL have ports: pcWrite, ifIdWrite, idExeWrite  output  1 each  write enables of the PC, IF/ID and ID/EXE registers.
REQ-009 SHALL have ports: ifIdFlush, idExeFlush  output  1 each  load a bubble (all-zero control) into that register on this edge.
REQ-010 SHALL have ports: halted  output  1  core halted after syscall; stallCount  output  16  saturating stall-cycle counter.

Function
REQ-011 SHALL implement FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-012 Load-use hazard SHALL be: exeMemRead=1, exeRt!=0, and (exeRt==idRs or (idUsesRt=1 and exeRt==idRt)).
REQ-013 Event priority in RUN SHALL be: memBusy > exeSyscall > exeBranchTaken > load-use > none.
REQ-014 RUN, no event: pcWrite=ifIdWrite=idExeWrite=1, both flushes 0.
REQ-015 RUN, load-use: pcWrite=0, ifIdWrite=0, idExeWrite=1, idExeFlush=1, ifIdFlush=0; exactly one bubble per hazard.
REQ-016 RUN, branch taken: pcWrite=1, ifIdWrite=1, idExeWrite=1, ifIdFlush=1, idExeFlush=1; any coincident load-use ignored.
REQ-017 RUN, syscall: pcWrite=0, ifIdFlush=1, idExeFlush=1, idExeWrite=1; next state DRAIN, drain counter loaded with 2.
REQ-018 DRAIN: pcWrite=0, ifIdWrite=0, idExeWrite=1, idExeFlush=1; counter decrements each non-busy cycle; at counter 0 next state HALTED (3 cycles total including syscall cycle).
REQ-019 HALTED: halted=1, all enables 0, all flushes 0; resume=1 -> RUN next edge; resume ignored in RUN and DRAIN.
REQ-020 memBusy=1 in any state: all enables 0, all flushes 0, FSM state and drain counter hold.
REQ-021 stallCount SHALL increment by 1 on each edge where state is RUN and (memBusy=1 or load-use wins priority); saturates at 0xFFFF, never wraps.
REQ-022 Enable/flush outputs SHALL be combinational from state and inputs; halted and stallCount registered.

Reset
REQ-023 reset=0 SHALL immediately, without clk, force state=RUN, drain counter=0, halted=0, stallCount=0.
REQ-024 While reset=0, pcWrite, ifIdWrite, idExeWrite, ifIdFlush, idExeFlush SHALL all be 0.
REQ-025 Reset asserted mid-DRAIN or in HALTED SHALL abandon the drain; after release the block is in RUN with no pending syscall.

Structure
REQ-026 Shared package SHALL hold the state encodings (RUN=0, DRAIN=1, HALTED=2), DRAIN_CYCLES=3, STALL_CNT_W=16.
REQ-027 Load-use comparison SHALL be a sub-module load_use_detect (purely combinational); FSM, counters and output decode stay in the top.

Verification
REQ-028 exeMemRead=1, exeRt=8, idRs=8 in RUN -> one cycle pcWrite=0, ifIdWrite=0, idExeFlush=1; stallCount 0->1; next cycle normal.
REQ-029 Same with exeRt=0, idRs=0 -> no stall, all enables 1, stallCount unchanged.
REQ-030 exeBranchTaken=1 together with load-use (exeRt=idRt=5, idUsesRt=1) -> ifIdFlush=idExeFlush=1, pcWrite=1, stallCount unchanged.
REQ-031 exeSyscall=1 pulse -> DRAIN for 2 further cycles, then halted=1 on the 3rd edge; resume pulse -> halted=0, pcWrite=1 next cycle.
REQ-032 memBusy=1 for 4 cycles during DRAIN -> all outputs 0, drain counter held; halt reached 4 cycles later than REQ-031; stallCount unchanged.
REQ-033 Preload stallCount to 0xFFFE via 3 busy cycles after forcing -> saturates at 0xFFFF; async reset=0 mid-clock-period -> stallCount=0, halted=0 immediately.
